// File: rtl/dzcpu_useq_pkg.sv
// Shared definitions for the dzcpu microcode sequencer: micro-op field
// positions, flow-control codes, the CB-jump operation and FSM states.
package dzcpu_useq_pkg;

    localparam int UPC_W = 8;
    localparam int UOP_W = 13;

    localparam logic [7:0] INT_FLOW_IDX_DEF = 8'd199;
    localparam logic [7:0] MAX_UPC_DEF      = 8'd255;

    // Micro-op layout: {ctl[3:0], operation[4:0], operand[3:0]}
    localparam int CTL_HI = 12;
    localparam int CTL_LO = 9;
    localparam int OPR_HI = 8;
    localparam int OPR_LO = 4;
    localparam int OPD_HI = 3;
    localparam int OPD_LO = 0;

    typedef enum logic [3:0] {
        CTL_OP         = 4'd0,
        CTL_INC        = 4'd1,
        CTL_EOF        = 4'd2,
        CTL_INC_EOF    = 4'd3,
        CTL_EOF_FU     = 4'd4,
        CTL_INC_EOF_FU = 4'd5,
        CTL_INC_EOF_Z  = 4'd6,
        CTL_INC_EOF_NZ = 4'd7,
        CTL_UPD_FLAGS  = 4'd8,
        CTL_NOP_CTL    = 4'd9
    } ctl_e;

    // Operation that latches the CB-prefixed opcode and re-dispatches.
    localparam logic [4:0] OPR_JCB = 5'd1;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_CBDEC  = 2'd3
    } state_e;

    // Decoded flow-control actions of one micro-op.
    typedef struct packed {
        logic pc_inc;
        logic flags_upd;
        logic end_flow;
        logic cond_z;
        logic cond_nz;
    } ctl_t;

endpackage

// File: rtl/dzcpu_useq_if.sv
// Bundle of the sequencer's datapath/ROM/LUT signals. The sequencer uses
// the master view; the surrounding core (or a bench) uses the slave view.
interface dzcpu_useq_if;
    import dzcpu_useq_pkg::*;

    logic [7:0]       iMemData;
    logic             iStall;
    logic [UOP_W-1:0] iUop;
    logic [UPC_W-1:0] iFlowIdx;
    logic [UPC_W-1:0] iCbFlowIdx;
    logic             iZero;
    logic             iIntReq;
    logic             iIme;

    logic [UPC_W-1:0] oUpc;
    logic [7:0]       oMop;
    logic [7:0]       oCbMop;
    logic             oExec;
    logic             oPcInc;
    logic             oFlagsUpdate;
    logic             oIntAck;
    logic             oUcodeErr;

    modport master (
        input  iMemData, iStall, iUop, iFlowIdx, iCbFlowIdx, iZero, iIntReq, iIme,
        output oUpc, oMop, oCbMop, oExec, oPcInc, oFlagsUpdate, oIntAck, oUcodeErr
    );

    modport slave (
        output iMemData, iStall, iUop, iFlowIdx, iCbFlowIdx, iZero, iIntReq, iIme,
        input  oUpc, oMop, oCbMop, oExec, oPcInc, oFlagsUpdate, oIntAck, oUcodeErr
    );

endinterface

// File: rtl/dzcpu_useq_ctl_dec.sv
// Combinational decode of a micro-op flow-control code into the actions
// the sequencer applies. Unknown codes decode as plain OP (step only).
module dzcpu_useq_ctl_dec
    import dzcpu_useq_pkg::*;
(
    input  logic [3:0] ctl,
    output ctl_t       dec
);

    // Map each control code onto its strobe / end-of-flow actions
    always_comb begin
        dec = '0;
        case (ctl)
            CTL_INC:        dec.pc_inc = 1'b1;
            CTL_EOF:        dec.end_flow = 1'b1;
            CTL_INC_EOF:    begin dec.pc_inc = 1'b1; dec.end_flow = 1'b1; end
            CTL_EOF_FU:     begin dec.flags_upd = 1'b1; dec.end_flow = 1'b1; end
            CTL_INC_EOF_FU: begin dec.pc_inc = 1'b1; dec.flags_upd = 1'b1; dec.end_flow = 1'b1; end
            CTL_INC_EOF_Z:  begin dec.pc_inc = 1'b1; dec.cond_z = 1'b1; end
            CTL_INC_EOF_NZ: begin dec.pc_inc = 1'b1; dec.cond_nz = 1'b1; end
            CTL_UPD_FLAGS:  dec.flags_upd = 1'b1;
            default:        dec = '0;
        endcase
    end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: owns the micro-PC, latches opcode / CB opcode
// bytes for the flow LUTs, walks each micro-flow and raises the per-uop
// datapath strobes. Interrupt flows are only dispatched between instructions.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter logic [UPC_W-1:0] INT_FLOW_IDX = INT_FLOW_IDX_DEF,
    parameter logic [UPC_W-1:0] MAX_UPC      = MAX_UPC_DEF
) (
    input  logic         iClock,
    input  logic         iReset,
    dzcpu_useq_if.master bus
);

    state_e           state;
    logic [UPC_W-1:0] upc;
    logic [7:0]       mop;
    logic [7:0]       cbmop;
    logic             ucode_err;

    logic [3:0] ctl;
    logic [4:0] opr;
    logic       unused_operand;
    ctl_t       dec;
    logic       active;
    logic       in_exec;
    logic       take_int;
    logic       flow_end;

    assign ctl            = bus.iUop[CTL_HI:CTL_LO];
    assign opr            = bus.iUop[OPR_HI:OPR_LO];
    assign unused_operand = ^bus.iUop[OPD_HI:OPD_LO];

    dzcpu_useq_ctl_dec u_ctl_dec (
        .ctl (ctl),
        .dec (dec)
    );

    // A stall freezes everything, including interrupt sampling.
    assign active   = !bus.iStall;
    assign in_exec  = (state == ST_EXEC) && active;
    assign take_int = (state == ST_FETCH) && active && bus.iIntReq && bus.iIme;
    assign flow_end = dec.end_flow | (dec.cond_z & bus.iZero) | (dec.cond_nz & ~bus.iZero);

    assign bus.oUpc         = upc;
    assign bus.oMop         = mop;
    assign bus.oCbMop       = cbmop;
    assign bus.oUcodeErr    = ucode_err;
    assign bus.oExec        = in_exec;
    assign bus.oPcInc       = in_exec & dec.pc_inc;
    assign bus.oFlagsUpdate = in_exec & dec.flags_upd;
    assign bus.oIntAck      = take_int;

    // Sequencer FSM: fetch/decode dispatch, micro-flow stepping, overrun trap
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= ST_FETCH;
            upc       <= '0;
            mop       <= '0;
            cbmop     <= '0;
            ucode_err <= 1'b0;
        end else if (active) begin
            case (state)
                ST_FETCH: begin
                    if (bus.iIntReq && bus.iIme) begin
                        upc   <= INT_FLOW_IDX;
                        state <= ST_EXEC;
                    end else begin
                        mop   <= bus.iMemData;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    upc   <= bus.iFlowIdx;
                    state <= ST_EXEC;
                end
                ST_CBDEC: begin
                    upc   <= bus.iCbFlowIdx;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opr == OPR_JCB) begin
                        // CB prefix: second opcode byte selects a new flow
                        cbmop <= bus.iMemData;
                        state <= ST_CBDEC;
                    end else if (flow_end) begin
                        state <= ST_FETCH;
                    end else if (upc == MAX_UPC) begin
                        // Flow ran off the end of the ROM; never wrap
                        ucode_err <= 1'b1;
                        state     <= ST_FETCH;
                    end else begin
                        upc <= upc + 1'b1;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Directed bench for dzcpu_useq with a ROM/LUT stub. Expected EXEC cycles
// are queued by the stimulus; a negedge monitor checks each one.
module tb_dzcpu_useq;
    import dzcpu_useq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dzcpu_useq_if bus();

    dzcpu_useq dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    logic [12:0] rom [256];

    function automatic logic [12:0] uop(input logic [3:0] c, input logic [4:0] o);
        return {c, o, 4'h0};
    endfunction

    function automatic logic [7:0] lut(input logic [7:0] op);
        case (op)
            8'h10:   return 8'd5;
            8'h20:   return 8'd19;
            8'h30:   return 8'd13;
            8'h40:   return 8'd50;
            8'h50:   return 8'd254;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] cblut(input logic [7:0] op);
        return (op == 8'h7C) ? 8'd16 : 8'd0;
    endfunction

    assign bus.iUop       = rom[bus.oUpc];
    assign bus.iFlowIdx   = lut(bus.oMop);
    assign bus.iCbFlowIdx = cblut(bus.oCbMop);

    typedef struct packed {
        logic [7:0] upc;
        logic       pc_inc;
        logic       fu;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] u, input logic p, input logic f);
        exp_t e;
        e.upc = u; e.pc_inc = p; e.fu = f;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every EXEC cycle must match the next queued expectation
    always @(negedge clk) begin
        if (bus.oExec === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL exec_unexpected: got exec at upc %0d, expected none at %0t", bus.oUpc, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exec_upc", 32'(bus.oUpc), 32'(e.upc));
                chk("exec_pcinc", 32'(bus.oPcInc), 32'(e.pc_inc));
                chk("exec_flagsupd", 32'(bus.oFlagsUpdate), 32'(e.fu));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = uop(CTL_OP, 5'd0);
        rom[0]   = uop(CTL_INC_EOF, 5'd0);
        rom[5]   = uop(CTL_INC, 5'd0);
        rom[6]   = uop(CTL_INC, 5'd0);
        rom[7]   = uop(CTL_OP, 5'd0);
        rom[8]   = uop(CTL_INC_EOF, 5'd0);
        rom[13]  = uop(CTL_INC, 5'd0);
        rom[14]  = uop(CTL_OP, 5'd0);
        rom[15]  = uop(CTL_INC, OPR_JCB);
        rom[16]  = uop(CTL_EOF_FU, 5'd0);
        rom[19]  = uop(CTL_INC_EOF_Z, 5'd0);
        rom[20]  = uop(CTL_EOF, 5'd0);
        rom[56]  = uop(CTL_EOF, 5'd0);
        rom[199] = uop(CTL_OP, 5'd0);
        rom[200] = uop(CTL_EOF, 5'd0);

        bus.iMemData = 8'h00; bus.iStall = 1'b0; bus.iZero = 1'b0;
        bus.iIntReq = 1'b0; bus.iIme = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(2);
        chk("rst_upc", 32'(bus.oUpc), 32'd0);
        chk("rst_mop", 32'(bus.oMop), 32'd0);
        chk("rst_cbmop", 32'(bus.oCbMop), 32'd0);
        chk("rst_err", 32'(bus.oUcodeErr), 32'd0);
        chk("rst_exec", 32'(bus.oExec), 32'd0);
        rst = 1'b0;

        // Default one-byte flow: 3 cycles
        bus.iMemData = 8'h00; push(8'd0, 1'b1, 1'b0);
        tick(3);

        // Four-uop flow: 6 cycles
        bus.iMemData = 8'h10;
        push(8'd5, 1, 0); push(8'd6, 1, 0); push(8'd7, 0, 0); push(8'd8, 1, 0);
        tick(6);

        // Conditional end, Z set: ends at 19
        bus.iZero = 1'b1; bus.iMemData = 8'h20;
        push(8'd19, 1, 0);
        tick(3);
        // Z clear: continues to 20
        bus.iZero = 1'b0;
        push(8'd19, 1, 0); push(8'd20, 0, 0);
        tick(4);

        // CB prefix
        bus.iMemData = 8'h30;
        push(8'd13, 1, 0); push(8'd14, 0, 0); push(8'd15, 1, 0); push(8'd16, 0, 1);
        tick(1);
        bus.iMemData = 8'h7C;
        tick(4);
        chk("cb_mop", 32'(bus.oCbMop), 32'h7C);
        tick(1);
        chk("cb_upc", 32'(bus.oUpc), 32'd16);
        chk("cb_mop_main", 32'(bus.oMop), 32'h30);
        tick(1);

        // Interrupt deferred by stall, then taken
        bus.iStall = 1'b1; bus.iIntReq = 1'b1; bus.iIme = 1'b1;
        #1;
        chk("stall_intack", 32'(bus.oIntAck), 32'd0);
        tick(1);
        chk("stall_intack2", 32'(bus.oIntAck), 32'd0);
        chk("stall_upc_hold", 32'(bus.oUpc), 32'd16);
        bus.iStall = 1'b0;
        #1;
        chk("intack", 32'(bus.oIntAck), 32'd1);
        push(8'd199, 0, 0); push(8'd200, 0, 0);
        tick(1);
        bus.iIntReq = 1'b0; bus.iIme = 1'b0;
        #1;
        chk("int_upc", 32'(bus.oUpc), 32'd199);
        chk("int_mop_keep", 32'(bus.oMop), 32'h30);
        chk("intack_once", 32'(bus.oIntAck), 32'd0);
        tick(2);

        // Stall mid-flow for 3 cycles
        bus.iMemData = 8'h40;
        push(8'd50, 0, 0);
        tick(2);
        push(8'd51, 0, 0);
        tick(1);
        bus.iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_upc", 32'(bus.oUpc), 32'd51);
            chk("stall_exec", 32'(bus.oExec), 32'd0);
            chk("stall_pcinc", 32'(bus.oPcInc), 32'd0);
            if (i < 2) tick(1);
        end
        bus.iStall = 1'b0;

        // Reset mid-flow at 52
        push(8'd52, 0, 0);
        tick(1);
        chk("pre_rst_upc", 32'(bus.oUpc), 32'd52);
        rst = 1'b1;
        tick(1);
        chk("midrst_upc", 32'(bus.oUpc), 32'd0);
        chk("midrst_mop", 32'(bus.oMop), 32'd0);
        chk("midrst_exec", 32'(bus.oExec), 32'd0);
        chk("midrst_pcinc", 32'(bus.oPcInc), 32'd0);
        chk("midrst_fu", 32'(bus.oFlagsUpdate), 32'd0);
        rst = 1'b0;

        // Overrun at MAX_UPC
        bus.iMemData = 8'h50;
        push(8'd254, 0, 0); push(8'd255, 0, 0);
        tick(4);
        chk("ovr_err", 32'(bus.oUcodeErr), 32'd1);
        chk("ovr_nowrap", 32'(bus.oUpc), 32'd255);
        bus.iMemData = 8'h00; push(8'd0, 1, 0);
        tick(3);
        chk("ovr_sticky", 32'(bus.oUcodeErr), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("ovr_clear", 32'(bus.oUcodeErr), 32'd0);
        rst = 1'b0;
        tick(1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
